// File: rtl/lsu_req_serializer_if.sv
// Operation intake, single-lane memory request/response port and completion
// signals for lsu_req_serializer. The serializer connects through the slave modport.
interface lsu_req_serializer_if;
    logic          in_valid;
    logic          in_ready;
    logic [2047:0] in_ld_st_addr;
    logic [63:0]   in_exec_mask;
    logic          in_gm_or_lds;
    logic          in_store;
    logic [2047:0] in_store_data;
    logic          out_mem_req_valid;
    logic          mem_req_ready;
    logic [31:0]   out_mem_addr;
    logic [5:0]    out_mem_tid;
    logic          out_mem_gm_or_lds;
    logic          out_mem_wr_en;
    logic [31:0]   out_mem_wr_data;
    logic          in_mem_rsp_valid;
    logic [5:0]    in_mem_rsp_tid;
    logic [31:0]   in_mem_rsp_data;
    logic [2047:0] out_load_data;
    logic          out_done;
    logic          out_busy;

    modport slave (
        input  in_valid, in_ld_st_addr, in_exec_mask, in_gm_or_lds, in_store, in_store_data,
        input  mem_req_ready, in_mem_rsp_valid, in_mem_rsp_tid, in_mem_rsp_data,
        output in_ready, out_mem_req_valid, out_mem_addr, out_mem_tid, out_mem_gm_or_lds,
        output out_mem_wr_en, out_mem_wr_data, out_load_data, out_done, out_busy
    );

    modport master (
        output in_valid, in_ld_st_addr, in_exec_mask, in_gm_or_lds, in_store, in_store_data,
        output mem_req_ready, in_mem_rsp_valid, in_mem_rsp_tid, in_mem_rsp_data,
        input  in_ready, out_mem_req_valid, out_mem_addr, out_mem_tid, out_mem_gm_or_lds,
        input  out_mem_wr_en, out_mem_wr_data, out_load_data, out_done, out_busy
    );
endinterface

// File: rtl/lsu_req_serializer.sv
// Serializes a wavefront memory operation into single-lane requests, lowest lane first,
// and assembles the per-lane responses into the 2048-bit load result.
//   state   | meaning
//   IDLE    | ready for a new operation
//   ISSUE   | lanes still waiting to be requested
//   DRAIN   | all lanes requested, waiting for responses
//   DONE    | one-cycle completion pulse
module lsu_req_serializer #(
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    lsu_req_serializer_if.slave        bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t        r_state;
    logic [2047:0] r_addr;
    logic [2047:0] r_wdata;
    logic [63:0]   r_mask;
    logic          r_lds;
    logic          r_store;
    logic [6:0]    r_outstanding;
    logic          r_req_valid;
    logic [31:0]   r_req_addr;
    logic [5:0]    r_req_tid;
    logic [31:0]   r_req_wdata;
    logic [2047:0] r_load_data;
    logic          r_done;
    logic          r_busy;
    logic          r_in_ready;

    logic          w_hs;
    logic          w_rsp_ok;
    logic [63:0]   w_mask_next;
    logic [6:0]    w_out_next;
    logic [5:0]    w_next_tid;
    logic [5:0]    w_acc_tid;
    logic          w_can_issue;
    logic [2047:0] w_clr_mask;

    function automatic logic [5:0] lowest_lane(input logic [63:0] m);
        logic [5:0] v;
        v = '0;
        for (int i = 63; i >= 0; i--) begin
            if (m[i]) v = 6'(i);
        end
        return v;
    endfunction

    function automatic logic [31:0] lane_addr(input logic [2047:0] a, input logic [5:0] t,
                                              input logic lds);
        logic [31:0] w;
        w = a[{t, 5'b0} +: 32];
        return lds ? {16'h0, w[15:0]} : w;
    endfunction

    always_comb begin
        w_hs        = r_req_valid && bus.mem_req_ready;
        // Responses only count against a live operation with something in flight.
        w_rsp_ok    = bus.in_mem_rsp_valid && (r_state != S_IDLE) && (r_outstanding != '0);
        w_mask_next = r_mask;
        if (w_hs) w_mask_next[r_req_tid] = 1'b0;
        w_out_next  = r_outstanding + {6'b0, w_hs} - {6'b0, w_rsp_ok};
        w_next_tid  = lowest_lane(w_mask_next);
        w_acc_tid   = lowest_lane(bus.in_exec_mask);
        w_can_issue = (w_mask_next != '0) && (w_out_next < 7'(MAX_OUTSTANDING));
        w_clr_mask  = '0;
        for (int i = 0; i < 64; i++) begin
            w_clr_mask[i*32 +: 32] = {32{bus.in_exec_mask[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.in_valid) begin
            r_addr  <= bus.in_ld_st_addr;
            r_wdata <= bus.in_store_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_mask        <= '0;
            r_lds         <= 1'b0;
            r_store       <= 1'b0;
            r_outstanding <= '0;
            r_req_valid   <= 1'b0;
            r_req_addr    <= '0;
            r_req_tid     <= '0;
            r_req_wdata   <= '0;
            r_load_data   <= '0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_in_ready    <= 1'b1;
        end else begin
            r_done        <= 1'b0;
            r_outstanding <= w_out_next;
            if (w_rsp_ok && !r_store) begin
                r_load_data[{bus.in_mem_rsp_tid, 5'b0} +: 32] <= bus.in_mem_rsp_data;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_mask      <= bus.in_exec_mask;
                        r_lds       <= bus.in_gm_or_lds;
                        r_store     <= bus.in_store;
                        r_load_data <= r_load_data & ~w_clr_mask;
                        r_busy      <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_req_tid   <= w_acc_tid;
                        r_req_addr  <= lane_addr(bus.in_ld_st_addr, w_acc_tid, bus.in_gm_or_lds);
                        r_req_wdata <= bus.in_store_data[{w_acc_tid, 5'b0} +: 32];
                        if (bus.in_exec_mask != '0) begin
                            r_state     <= S_ISSUE;
                            r_req_valid <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_mask <= w_mask_next;
                    // A request offered but not taken must hold every field.
                    if (!r_req_valid || bus.mem_req_ready) begin
                        r_req_valid <= w_can_issue;
                        r_req_tid   <= w_next_tid;
                        r_req_addr  <= lane_addr(r_addr, w_next_tid, r_lds);
                        r_req_wdata <= r_wdata[{w_next_tid, 5'b0} +: 32];
                    end
                    if (w_mask_next == '0) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_out_next == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready          = r_in_ready;
    assign bus.out_mem_req_valid = r_req_valid;
    assign bus.out_mem_addr      = r_req_addr;
    assign bus.out_mem_tid       = r_req_tid;
    assign bus.out_mem_gm_or_lds = r_lds;
    assign bus.out_mem_wr_en     = r_store;
    assign bus.out_mem_wr_data   = r_req_wdata;
    assign bus.out_load_data     = r_load_data;
    assign bus.out_done          = r_done;
    assign bus.out_busy          = r_busy;
endmodule

// File: doc/lsu_req_serializer.md
Name: lsu_req_serializer

Overview:
- Sits directly downstream of the LSU address calculator. Takes one wavefront-wide memory operation per accept: 64 per-lane 32-bit addresses, the exec mask, the GM/LDS select, and store data.
- Serializes active lanes, lowest lane first, into single-lane requests on a valid/ready memory port.
- Collects one response per request, assembles the 2048-bit load result, and pulses done once all responses have returned.

Parameters:
- MAX_OUTSTANDING, 16, maximum issued-but-unanswered requests; range 1..64.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept an operation
- in_ld_st_addr  input  2048  lane i address at [32i+31:32i]
- in_exec_mask  input  64  active lanes
- in_gm_or_lds  input  1  1=LDS, 0=global memory
- in_store  input  1  1=store, 0=load
- in_store_data  input  2048  lane i store data at [32i+31:32i]
- out_mem_req_valid  output  1  request valid
- mem_req_ready  input  1  memory accepts request
- out_mem_addr  output  32  request address
- out_mem_tid  output  6  lane index of request
- out_mem_gm_or_lds  output  1  captured in_gm_or_lds
- out_mem_wr_en  output  1  captured in_store
- out_mem_wr_data  output  32  lane store data
- in_mem_rsp_valid  input  1  response valid; always accepted
- in_mem_rsp_tid  input  6  lane of response
- in_mem_rsp_data  input  32  load data; ignored for stores
- out_load_data  output  2048  assembled load result
- out_done  output  1  one-cycle completion pulse
- out_busy  output  1  state != IDLE

Behaviour:
- Reset (rst low at a clk edge):
  - state to IDLE; remaining mask and outstanding count to 0.
  - out_mem_req_valid=0, out_done=0, out_busy=0, out_load_data=0, in_ready=1.
  - Applies mid-operation: all captured state is dropped. An in-flight request is withdrawn the cycle after reset, and late responses are ignored while in IDLE.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture addresses, data, mask, gm_or_lds and store flag.
  - Clear out_load_data lanes set in the mask; other lanes keep their old value.
  - Go to ISSUE, or to DONE if the mask is zero.
- ISSUE:
  - out_mem_req_valid=1 with the lowest set lane of the remaining mask, unless outstanding == MAX_OUTSTANDING (valid=0, stall).
  - First request is valid the cycle after accept.
  - While valid and not ready, all request outputs stay stable.
  - On handshake: clear that lane's bit and increment outstanding.
  - When the last bit clears, go to DRAIN.
- Request address:
  - GM: the lane's full 32 bits.
  - LDS: {16'b0, addr[15:0]}.
- Responses (any state except IDLE):
  - Each response decrements outstanding.
  - For loads, it writes in_mem_rsp_data into lane in_mem_rsp_tid of out_load_data.
  - A response arriving while outstanding == 0 is ignored.
  - Handshake and response in the same cycle leave outstanding unchanged; the lane write still occurs.
  - Responses may arrive out of order.
- DRAIN:
  - out_mem_req_valid=0.
  - When outstanding reaches 0, counting a response in the current cycle, go to DONE.
- DONE:
  - out_done=1 for exactly one cycle, then IDLE.
  - out_load_data is stable from the done cycle until the next accept.
- Latency with mem_req_ready always high, responses one cycle later, and N active lanes: done asserts N+2 cycles after the accept cycle. With N=0, done asserts the cycle after accept.
- out_busy=1 in ISSUE, DRAIN and DONE. in_ready=0 outside IDLE.

Test Plan:
- Mask 64'h1, GM load, lane0 addr 32'h1000, ready=1, response data 32'hDEAD0001 → one request (addr 32'h1000, tid 0, wr_en 0); out_load_data[31:0]=32'hDEAD0001; done 3 cycles after accept.
- Mask 64'h8000_0000_0000_0005, LDS store, lane addrs 32'hABCD0010 → requests in order tid 0, 2, 63, each with addr 32'h00000010 and the matching lane data; done after 3 responses.
- Mask all-ones, MAX_OUTSTANDING=16, responses withheld → exactly 16 handshakes then valid=0. Releasing one response yields exactly one more request.
- mem_req_ready low for 5 cycles mid-stream → valid, addr, tid and data held constant across those cycles; no lane skipped or duplicated.
- Mask 0 → no requests; out_done pulses the cycle after accept; in_ready returns to 1.
- rst low during ISSUE with 3 outstanding → next cycle valid=0, busy=0, in_ready=1. The 3 late responses leave out_load_data at 0, and a new operation then completes normally.
